// File: rtl/ppg_binsearch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ppg_binsearch_ctrl_if
//  Description : Host/clip-side signal bundle of the PPG calibration controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface ppg_binsearch_ctrl_if;
    logic       start;
    logic [7:0] Vppg;
    logic       LED_RED;
    logic       LED_IR;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic       busy;
    logic       done;
    logic [6:0] dc_red;
    logic [6:0] dc_ir;
    logic [3:0] pga_red;
    logic [3:0] pga_ir;

    // Host / clip side
    modport master (
        output start, Vppg,
        input  LED_RED, LED_IR, DC_Comp, PGA_Gain, busy, done,
        input  dc_red, dc_ir, pga_red, pga_ir
    );

    // Controller side
    modport slave (
        input  start, Vppg,
        output LED_RED, LED_IR, DC_Comp, PGA_Gain, busy, done,
        output dc_red, dc_ir, pga_red, pga_ir
    );
endinterface
`default_nettype wire

// File: rtl/ppg_binsearch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ppg_binsearch_ctrl
//  Description : Per-LED binary-search calibration of DC_Comp then PGA_Gain
//                for the fingerclip PPG channel (RED pass, then IR pass).
//  Revision    : 1.0  initial release
// ============================================================================
module ppg_binsearch_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 64,
    parameter int TARGET        = 128,
    parameter int LO_LIM        = 16,
    parameter int HI_LIM        = 239
) (
    input  logic                 clk,
    input  logic                 reset,
    ppg_binsearch_ctrl_if.slave  bus
);

    localparam int c_CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam bit c_HAS_SETTLE = (SETTLE_CYCLES > 0);

    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WINDOW_LAST = c_CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [8:0]         c_TARGET      = 9'(TARGET);
    localparam logic [7:0]         c_LO_LIM      = 8'(LO_LIM);
    localparam logic [7:0]         c_HI_LIM      = 8'(HI_LIM);
    localparam logic [2:0]         c_DC_MSB      = 3'd6;
    localparam logic [2:0]         c_PGA_MSB     = 3'd3;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LED_ON     = 4'd1,
        S_DC_TRIAL   = 4'd2,
        S_SETTLE     = 4'd3,
        S_MEAS       = 4'd4,
        S_DC_DECIDE  = 4'd5,
        S_PGA_TRIAL  = 4'd6,
        S_PGA_DECIDE = 4'd7,
        S_STORE      = 4'd8,
        S_LED_OFF    = 4'd9,
        S_DONE       = 4'd10
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_led_ir;     // 0: RED pass, 1: IR pass
    logic                 r_pga_phase;  // SETTLE/MEAS belong to the PGA search
    logic [2:0]           r_bit;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [6:0]           r_dc;
    logic [3:0]           r_pga;
    logic [7:0]           r_min;
    logic [7:0]           r_max;
    logic [6:0]           r_dc_red;
    logic [6:0]           r_dc_ir;
    logic [3:0]           r_pga_red;
    logic [3:0]           r_pga_ir;

    logic [8:0]           w_sum;
    logic [8:0]           w_mid;
    logic                 w_dc_keep;
    logic                 w_pga_keep;
    logic [6:0]           w_dc_mask;
    logic [3:0]           w_pga_mask;
    logic                 w_led_active;
    logic                 w_cnt_run;

    // Decision terms; the 9-bit sum cannot overflow
    assign w_sum      = {1'b0, r_max} + {1'b0, r_min};
    assign w_mid      = w_sum >> 1;
    assign w_dc_keep  = (w_mid >= c_TARGET);
    assign w_pga_keep = (r_min >= c_LO_LIM) && (r_max <= c_HI_LIM);
    assign w_dc_mask  = 7'(7'd1 << r_bit);
    assign w_pga_mask = 4'(4'd1 << r_bit[1:0]);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_LED_ON;
                end
            end
            S_LED_ON: begin
                w_next = S_DC_TRIAL;
            end
            S_DC_TRIAL, S_PGA_TRIAL: begin
                w_next = c_HAS_SETTLE ? S_SETTLE : S_MEAS;
            end
            S_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_next = S_MEAS;
                end
            end
            S_MEAS: begin
                if (r_cnt == c_WINDOW_LAST) begin
                    w_next = r_pga_phase ? S_PGA_DECIDE : S_DC_DECIDE;
                end
            end
            S_DC_DECIDE: begin
                w_next = (r_bit == 3'd0) ? S_PGA_TRIAL : S_DC_TRIAL;
            end
            S_PGA_DECIDE: begin
                w_next = (r_bit == 3'd0) ? S_STORE : S_PGA_TRIAL;
            end
            S_STORE: begin
                w_next = S_LED_OFF;
            end
            S_LED_OFF: begin
                w_next = r_led_ir ? S_DONE : S_LED_ON;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // A counter keeps running only while the FSM stays in SETTLE or MEAS
    assign w_cnt_run = (w_next == r_state) &&
                       ((r_state == S_SETTLE) || (r_state == S_MEAS));

    // ------------------------------------------------------------------
    // Search datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led_ir    <= 1'b0;
            r_pga_phase <= 1'b0;
            r_bit       <= 3'd0;
            r_cnt       <= '0;
            r_dc        <= 7'd0;
            r_pga       <= 4'd0;
            r_min       <= 8'd0;
            r_max       <= 8'd0;
            r_dc_red    <= 7'd0;
            r_dc_ir     <= 7'd0;
            r_pga_red   <= 4'd0;
            r_pga_ir    <= 4'd0;
        end else begin
            r_cnt <= w_cnt_run ? c_CNT_W'(r_cnt + 1'b1) : '0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_led_ir  <= 1'b0;
                        r_dc_red  <= 7'd0;
                        r_dc_ir   <= 7'd0;
                        r_pga_red <= 4'd0;
                        r_pga_ir  <= 4'd0;
                    end
                end
                S_LED_ON: begin
                    r_dc        <= 7'd0;
                    r_pga       <= 4'd0;
                    r_bit       <= c_DC_MSB;
                    r_pga_phase <= 1'b0;
                end
                S_DC_TRIAL: begin
                    r_dc <= r_dc | w_dc_mask;
                end
                S_PGA_TRIAL: begin
                    r_pga <= r_pga | w_pga_mask;
                end
                S_MEAS: begin
                    // First window sample seeds both extremes
                    if (r_cnt == '0) begin
                        r_min <= bus.Vppg;
                        r_max <= bus.Vppg;
                    end else begin
                        if (bus.Vppg < r_min) r_min <= bus.Vppg;
                        if (bus.Vppg > r_max) r_max <= bus.Vppg;
                    end
                end
                S_DC_DECIDE: begin
                    if (!w_dc_keep) begin
                        r_dc <= r_dc & ~w_dc_mask;
                    end
                    if (r_bit == 3'd0) begin
                        r_bit       <= c_PGA_MSB;
                        r_pga_phase <= 1'b1;
                    end else begin
                        r_bit <= 3'(r_bit - 3'd1);
                    end
                end
                S_PGA_DECIDE: begin
                    if (!w_pga_keep) begin
                        r_pga <= r_pga & ~w_pga_mask;
                    end
                    if (r_bit != 3'd0) begin
                        r_bit <= 3'(r_bit - 3'd1);
                    end
                end
                S_STORE: begin
                    if (r_led_ir) begin
                        r_dc_ir  <= r_dc;
                        r_pga_ir <= r_pga;
                    end else begin
                        r_dc_red  <= r_dc;
                        r_pga_red <= r_pga;
                    end
                    r_dc  <= 7'd0;
                    r_pga <= 4'd0;
                end
                S_LED_OFF: begin
                    r_led_ir <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: LEDs decoded from state so LED_OFF/IDLE/DONE force both low
    // ------------------------------------------------------------------
    assign w_led_active = (r_state != S_IDLE) && (r_state != S_LED_OFF) &&
                          (r_state != S_DONE);

    assign bus.LED_RED  = w_led_active && !r_led_ir;
    assign bus.LED_IR   = w_led_active &&  r_led_ir;
    assign bus.DC_Comp  = r_dc;
    assign bus.PGA_Gain = r_pga;
    assign bus.busy     = w_led_active || (r_state == S_LED_OFF);
    assign bus.done     = (r_state == S_DONE);
    assign bus.dc_red   = r_dc_red;
    assign bus.dc_ir    = r_dc_ir;
    assign bus.pga_red  = r_pga_red;
    assign bus.pga_ir   = r_pga_ir;

endmodule
`default_nettype wire

// File: tb/tb_ppg_binsearch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppg_binsearch_ctrl
//  Description : Directed self-checking bench with a behavioural clip stub.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ppg_binsearch_ctrl;

    localparam int c_SETTLE  = 16;
    localparam int c_WINDOW  = 64;
    localparam int c_LAT     = 1 + 11 * (1 + c_SETTLE + c_WINDOW + 1) + 1 + 1;  // 905
    localparam int c_TIMEOUT = 4000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic r_ph  = 1'b0;
    int   mode  = 0;    // 0 plain, 1 ripple, 2 IR offset, 3 stuck 0, 4 stuck 255
    int   v_tmp;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_done    = 0;
    int n_overlap = 0;
    int low_run   = 0;
    int ir_gap    = -1;
    logic prev_ir = 1'b0;

    ppg_binsearch_ctrl_if u_if ();

    ppg_binsearch_ctrl #(
        .SETTLE_CYCLES (c_SETTLE),
        .WINDOW_CYCLES (c_WINDOW),
        .TARGET        (128),
        .LO_LIM        (16),
        .HI_LIM        (239)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) r_ph <= ~r_ph;

    // Clip stub: centre falls 2 LSB per DC code; optional square ripple of 16*PGA
    always_comb begin
        v_tmp = 255 - 2 * int'(u_if.DC_Comp);
        if (mode == 2 && u_if.LED_IR) v_tmp = 235 - 2 * int'(u_if.DC_Comp);
        if (mode == 1) v_tmp = r_ph ? v_tmp + 16 * int'(u_if.PGA_Gain)
                                    : v_tmp - 16 * int'(u_if.PGA_Gain);
        if (mode == 3) v_tmp = 0;
        if (mode == 4) v_tmp = 255;
        if (v_tmp < 0)   v_tmp = 0;
        if (v_tmp > 255) v_tmp = 255;
        u_if.Vppg = 8'(v_tmp);
    end

    always @(negedge clk) begin
        if (u_if.LED_RED && u_if.LED_IR) n_overlap++;
        if (u_if.LED_IR && !prev_ir) ir_gap = low_run;
        if (u_if.LED_RED || u_if.LED_IR) low_run = 0;
        else                             low_run++;
        prev_ir = u_if.LED_IR;
        if (u_if.done) n_done++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pulse start and wait for done; optionally poke start while busy and in DONE
    task automatic run_cal(input string tag, input bit poke);
        int n;
        int d0;
        n  = 0;
        d0 = n_done;
        u_if.start = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        check_eq({tag, "_busy"}, 32'(u_if.busy), 32'd1);
        while (!u_if.done && n < c_TIMEOUT) begin
            u_if.start = poke && (n == 100);
            @(posedge clk); #1;
            n++;
        end
        u_if.start = 1'b0;
        check_eq({tag, "_latency"}, 32'(n), 32'(2 * c_LAT));
        check_eq({tag, "_busy_at_done"}, 32'(u_if.busy), 32'd0);
        check_eq({tag, "_codes_at_done"}, 32'({u_if.DC_Comp, u_if.PGA_Gain, u_if.LED_RED, u_if.LED_IR}), 32'd0);
        if (poke) u_if.start = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        check_eq({tag, "_idle_after"}, 32'({u_if.busy, u_if.done}), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq({tag, "_done_pulses"}, 32'(n_done - d0), 32'd1);
    endtask

    task automatic check_results(input string tag, input int dr, input int pr, input int di, input int pi);
        check_eq({tag, "_dc_red"},  32'(u_if.dc_red),  32'(dr));
        check_eq({tag, "_pga_red"}, 32'(u_if.pga_red), 32'(pr));
        check_eq({tag, "_dc_ir"},   32'(u_if.dc_ir),   32'(di));
        check_eq({tag, "_pga_ir"},  32'(u_if.pga_ir),  32'(pi));
    endtask

    initial begin
        int d0;
        u_if.start = 1'b0;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", 32'({u_if.LED_RED, u_if.LED_IR, u_if.DC_Comp, u_if.PGA_Gain,
                                       u_if.busy, u_if.done}), 32'd0);
        check_results("reset", 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: plain stub, centre 255-2*DC -> 63; flat signal keeps every gain bit
        mode = 0;
        run_cal("t1", 1'b0);
        check_results("t1", 63, 15, 63, 15);

        // 2: ripple +/-16*gain around 129 -> gain 7 hits 241 > 239, result 6
        mode = 1;
        run_cal("t2", 1'b0);
        check_results("t2", 63, 6, 63, 6);

        // 3: IR centre 235-2*DC -> 53; one dark cycle between passes
        mode   = 2;
        ir_gap = -1;
        run_cal("t3", 1'b0);
        check_results("t3", 63, 15, 53, 15);
        check_eq("t3_led_gap", 32'(ir_gap), 32'd1);

        // 4: reset during the 3rd DC trial (cycle 170 after start), with start also high
        mode = 0;
        d0   = n_done;
        u_if.start = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        repeat (169) @(posedge clk);
        #1;
        check_eq("t4_dc_trial3", 32'(u_if.DC_Comp), 32'd48);
        reset      = 1'b1;
        u_if.start = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        u_if.start = 1'b0;
        check_eq("t4_reset_outputs", 32'({u_if.LED_RED, u_if.LED_IR, u_if.DC_Comp, u_if.PGA_Gain,
                                          u_if.busy, u_if.done}), 32'd0);
        check_results("t4_reset", 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t4_stays_idle", 32'(u_if.busy), 32'd0);
        check_eq("t4_no_done", 32'(n_done - d0), 32'd0);
        run_cal("t4", 1'b0);
        check_results("t4", 63, 15, 63, 15);

        // 5: start while busy and in the DONE cycle are both ignored
        run_cal("t5", 1'b1);
        check_results("t5", 63, 15, 63, 15);

        // 6: stuck inputs
        mode = 3;
        run_cal("t6a", 1'b0);
        check_results("t6a", 0, 0, 0, 0);
        mode = 4;
        run_cal("t6b", 1'b0);
        check_results("t6b", 127, 0, 127, 0);

        check_eq("led_overlap", 32'(n_overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
